// File: rtl/fp_lsu_if.sv
// fp_lsu_if: request, DCCM and writeback signals of the FP load/store unit.
// Signal names keep their _i/_o suffixes as seen from the LSU itself.
// The master modport is the LSU's own view.
// The slave modport is the environment's view: FP decode, DCCM arbiter and FP register file.
interface fp_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_store_i;
    logic [4:0]        req_frd_i;
    logic [ADDR_W-1:0] req_base_i;
    logic [11:0]       req_offset_i;
    logic [31:0]       req_wdata_i;
    logic              dccm_req_o;
    logic              dccm_gnt_i;
    logic              dccm_we_o;
    logic [ADDR_W-1:0] dccm_addr_o;
    logic [31:0]       dccm_wdata_o;
    logic              dccm_rvalid_i;
    logic [31:0]       dccm_rdata_i;
    logic              wb_valid_o;
    logic              wb_ready_i;
    logic [4:0]        wb_frd_o;
    logic [31:0]       wb_data_o;
    logic              busy_o;
    logic              misalign_o;
    logic [ADDR_W-1:0] err_addr_o;

    modport master (
        input  req_valid_i, req_store_i, req_frd_i, req_base_i, req_offset_i, req_wdata_i,
        input  dccm_gnt_i, dccm_rvalid_i, dccm_rdata_i, wb_ready_i,
        output req_ready_o, dccm_req_o, dccm_we_o, dccm_addr_o, dccm_wdata_o,
        output wb_valid_o, wb_frd_o, wb_data_o, busy_o, misalign_o, err_addr_o
    );

    modport slave (
        output req_valid_i, req_store_i, req_frd_i, req_base_i, req_offset_i, req_wdata_i,
        output dccm_gnt_i, dccm_rvalid_i, dccm_rdata_i, wb_ready_i,
        input  req_ready_o, dccm_req_o, dccm_we_o, dccm_addr_o, dccm_wdata_o,
        input  wb_valid_o, wb_frd_o, wb_data_o, busy_o, misalign_o, err_addr_o
    );
endinterface

// File: rtl/fp_lsu.sv
// fp_lsu: single-outstanding FLW/FSW unit between FP issue and the DCCM arbiter.
// It computes base + sext(offset) and runs one req/gnt/rvalid word access.
// Load data returns to the FP register file over a valid/ready writeback port.
// Optional macro FP_LSU_MISALIGN_TRAP_EN traps misaligned addresses.
// When the macro is undefined, address bits [1:0] are forced to zero.
module fp_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic     clk_i,
    input  logic     rst_i,
    fp_lsu_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-1:0] w_offset_ext;
    logic [ADDR_W-1:0] w_ea;
    logic              w_accept;
    logic              w_trap;
    logic              w_issue;

    logic              r_dccm_req;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_wb_valid;
    logic [4:0]        r_frd;
    logic [31:0]       r_rdata;

    // The effective address wraps modulo 2^ADDR_W; wrap-around is not an error.
    assign w_offset_ext = {{(ADDR_W-12){bus.req_offset_i[11]}}, bus.req_offset_i};
    assign w_ea         = bus.req_base_i + w_offset_ext;
    assign w_accept     = bus.req_valid_i && (r_state == ST_IDLE);

`ifdef FP_LSU_MISALIGN_TRAP_EN
    // A trapped request is still accepted, but it never leaves IDLE.
    assign w_trap = w_accept && (w_ea[1:0] != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    assign w_issue = w_accept && !w_trap;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    // An rvalid outside WAIT never advances the FSM.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.dccm_gnt_i) begin
                    if (r_we) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (bus.dccm_rvalid_i) begin
                    w_state_nxt = ST_WB;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WB: begin
                if (bus.wb_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_WB;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered DCCM and writeback outputs.
    // The request fields are captured on accept and stay stable for the whole access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dccm_req <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_wdata    <= 32'h0000_0000;
            r_wb_valid <= 1'b0;
            r_frd      <= 5'd0;
            r_rdata    <= 32'h0000_0000;
        end else begin
            r_dccm_req <= (w_state_nxt == ST_ISSUE);
            r_wb_valid <= (w_state_nxt == ST_WB);
            if (w_issue) begin
                r_we    <= bus.req_store_i;
                r_addr  <= w_ea & ADDR_MASK;
                r_wdata <= bus.req_store_i ? bus.req_wdata_i : 32'h0000_0000;
                r_frd   <= bus.req_frd_i;
            end
            if ((r_state == ST_WAIT) && bus.dccm_rvalid_i) begin
                r_rdata <= bus.dccm_rdata_i;
            end
        end
    end

`ifdef FP_LSU_MISALIGN_TRAP_EN
    logic              r_misalign;
    logic [ADDR_W-1:0] r_err_addr;

    // One-cycle misalign pulse.
    // The faulting address is held until the next trap or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
            r_err_addr <= {ADDR_W{1'b0}};
        end else begin
            r_misalign <= w_trap;
            if (w_trap) begin
                r_err_addr <= w_ea;
            end
        end
    end

    assign bus.misalign_o = r_misalign;
    assign bus.err_addr_o = r_err_addr;
`else
    assign bus.misalign_o = 1'b0;
    assign bus.err_addr_o = {ADDR_W{1'b0}};
`endif

    assign bus.req_ready_o  = (r_state == ST_IDLE);
    assign bus.busy_o       = (r_state != ST_IDLE);
    assign bus.dccm_req_o   = r_dccm_req;
    assign bus.dccm_we_o    = r_we;
    assign bus.dccm_addr_o  = r_addr;
    assign bus.dccm_wdata_o = r_wdata;
    assign bus.wb_valid_o   = r_wb_valid;
    assign bus.wb_frd_o     = r_frd;
    assign bus.wb_data_o    = r_rdata;

endmodule

// File: tb/tb_fp_lsu.sv
// tb_fp_lsu: table-driven directed bench for fp_lsu.
// It includes hand-written sequences for misalignment and reset during WAIT.
// FP_LSU_MISALIGN_TRAP_EN selects which misalignment behaviour is expected.
module tb_fp_lsu;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fp_lsu_if #(.ADDR_W(32)) u_if ();

    fp_lsu #(.ADDR_W(32)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        store;
        logic [4:0]  frd;
        logic [31:0] base;
        logic [11:0] off;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        int          wb_dly;
        logic        rv_at_gnt;
        logic        rv_in_wb;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        u_if.req_valid_i   = 1'b0;
        u_if.req_store_i   = 1'b0;
        u_if.req_frd_i     = 5'd0;
        u_if.req_base_i    = 32'h0;
        u_if.req_offset_i  = 12'h0;
        u_if.req_wdata_i   = 32'h0;
        u_if.dccm_gnt_i    = 1'b0;
        u_if.dccm_rvalid_i = 1'b0;
        u_if.dccm_rdata_i  = 32'hEEEE_EEEE;
        u_if.wb_ready_i    = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"},    32'(u_if.req_ready_o), 32'd1);
        chk({tag, "_busy"},     32'(u_if.busy_o), 32'd0);
        chk({tag, "_dreq"},     32'(u_if.dccm_req_o), 32'd0);
        chk({tag, "_we"},       32'(u_if.dccm_we_o), 32'd0);
        chk({tag, "_addr"},     u_if.dccm_addr_o, 32'h0);
        chk({tag, "_wdata"},    u_if.dccm_wdata_o, 32'h0);
        chk({tag, "_wbv"},      32'(u_if.wb_valid_o), 32'd0);
        chk({tag, "_frd"},      32'(u_if.wb_frd_o), 32'd0);
        chk({tag, "_wbdata"},   u_if.wb_data_o, 32'h0);
        chk({tag, "_misalign"}, 32'(u_if.misalign_o), 32'd0);
        chk({tag, "_erraddr"},  u_if.err_addr_o, 32'h0);
    endtask

    // Runs one access with the given stall profile and checks every cycle.
    // Starts and ends on a negedge with the unit expected in IDLE.
    task automatic run_vec(input int idx, input vec_t v);
        string t;
        t = $sformatf("v%0d", idx);
        // Cycle N: accept.
        chk({t, "_ready_pre"}, 32'(u_if.req_ready_o), 32'd1);
        u_if.req_valid_i  = 1'b1;
        u_if.req_store_i  = v.store;
        u_if.req_frd_i    = v.frd;
        u_if.req_base_i   = v.base;
        u_if.req_offset_i = v.off;
        u_if.req_wdata_i  = v.wdata;
        @(negedge clk);
        u_if.req_valid_i  = 1'b0;
        u_if.req_wdata_i  = 32'h5555_AAAA;
        // Cycle N+1: ISSUE.
        chk({t, "_dreq"},  32'(u_if.dccm_req_o), 32'd1);
        chk({t, "_addr"},  u_if.dccm_addr_o, v.exp_addr);
        chk({t, "_we"},    32'(u_if.dccm_we_o), 32'(v.store));
        chk({t, "_wdata"}, u_if.dccm_wdata_o, v.exp_wdata);
        chk({t, "_ready_busy"}, 32'(u_if.req_ready_o), 32'd0);
        for (int i = 0; i < v.gnt_dly; i++) begin
            u_if.dccm_gnt_i = 1'b0;
            @(negedge clk);
            chk({t, "_stall_dreq"},  32'(u_if.dccm_req_o), 32'd1);
            chk({t, "_stall_addr"},  u_if.dccm_addr_o, v.exp_addr);
            chk({t, "_stall_wdata"}, u_if.dccm_wdata_o, v.exp_wdata);
        end
        u_if.dccm_gnt_i = 1'b1;
        if (v.rv_at_gnt) begin
            u_if.dccm_rvalid_i = 1'b1;
            u_if.dccm_rdata_i  = 32'hBAD0_BAD0;
        end
        @(negedge clk);
        u_if.dccm_gnt_i    = 1'b0;
        u_if.dccm_rvalid_i = 1'b0;
        u_if.dccm_rdata_i  = 32'hEEEE_EEEE;
        chk({t, "_dreq_drop"}, 32'(u_if.dccm_req_o), 32'd0);
        if (v.store) begin
            chk({t, "_st_ready"}, 32'(u_if.req_ready_o), 32'd1);
            chk({t, "_st_wbv"},   32'(u_if.wb_valid_o), 32'd0);
        end else begin
            // WAIT cycles.
            for (int i = 0; i < v.rv_dly; i++) begin
                chk({t, "_wait_wbv"},  32'(u_if.wb_valid_o), 32'd0);
                chk({t, "_wait_busy"}, 32'(u_if.busy_o), 32'd1);
                @(negedge clk);
            end
            chk({t, "_wait_wbv0"}, 32'(u_if.wb_valid_o), 32'd0);
            u_if.dccm_rvalid_i = 1'b1;
            u_if.dccm_rdata_i  = v.rdata;
            @(negedge clk);
            u_if.dccm_rvalid_i = 1'b0;
            u_if.dccm_rdata_i  = 32'hEEEE_EEEE;
            // WB cycles.
            chk({t, "_wbv"},    32'(u_if.wb_valid_o), 32'd1);
            chk({t, "_wbfrd"},  32'(u_if.wb_frd_o), 32'(v.frd));
            chk({t, "_wbdata"}, u_if.wb_data_o, v.rdata);
            for (int i = 0; i < v.wb_dly; i++) begin
                u_if.wb_ready_i = 1'b0;
                if (v.rv_in_wb) begin
                    u_if.dccm_rvalid_i = 1'b1;
                    u_if.dccm_rdata_i  = 32'h0BAD_0BAD;
                end
                @(negedge clk);
                u_if.dccm_rvalid_i = 1'b0;
                u_if.dccm_rdata_i  = 32'hEEEE_EEEE;
                chk({t, "_bp_wbv"},   32'(u_if.wb_valid_o), 32'd1);
                chk({t, "_bp_data"},  u_if.wb_data_o, v.rdata);
                chk({t, "_bp_frd"},   32'(u_if.wb_frd_o), 32'(v.frd));
                chk({t, "_bp_ready"}, 32'(u_if.req_ready_o), 32'd0);
            end
            u_if.wb_ready_i = 1'b1;
            @(negedge clk);
            u_if.wb_ready_i = 1'b0;
            chk({t, "_ld_wbv_drop"}, 32'(u_if.wb_valid_o), 32'd0);
            chk({t, "_ld_ready"},    32'(u_if.req_ready_o), 32'd1);
        end
    endtask

    // Safety net against a hung simulation.
    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // Main stimulus.
    initial begin
        checks   = 0;
        failures = 0;
        //            st    frd    base           off      wdata          rdata          g  r  w  rg    rw    exp_addr       exp_wdata
        vecs[0] = '{1'b0, 5'd5,  32'h0000_1000, 12'h010, 32'h0,         32'h3F80_0000, 0, 0, 0, 1'b0, 1'b0, 32'h0000_1010, 32'h0};
        vecs[1] = '{1'b1, 5'd0,  32'h0000_2000, 12'hFFC, 32'hDEAD_BEEF, 32'h0,         3, 0, 0, 1'b0, 1'b0, 32'h0000_1FFC, 32'hDEAD_BEEF};
        vecs[2] = '{1'b0, 5'd31, 32'hFFFF_FFFC, 12'h008, 32'h0,         32'h1234_5678, 0, 0, 0, 1'b0, 1'b0, 32'h0000_0004, 32'h0};
        vecs[3] = '{1'b0, 5'd1,  32'h0000_4000, 12'h7FC, 32'h7777_7777, 32'hC049_0FDB, 0, 0, 4, 1'b0, 1'b1, 32'h0000_47FC, 32'h0};
        vecs[4] = '{1'b0, 5'd17, 32'h8000_0000, 12'h800, 32'h0,         32'hA5A5_5A5A, 1, 2, 0, 1'b1, 1'b0, 32'h7FFF_F800, 32'h0};
        vecs[5] = '{1'b1, 5'd3,  32'h0000_0100, 12'h004, 32'h0BAD_F00D, 32'h0,         0, 0, 0, 1'b0, 1'b0, 32'h0000_0104, 32'h0BAD_F00D};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_all_zero("reset");

        for (int k = 0; k < 6; k++) begin
            run_vec(k, vecs[k]);
        end

        // Misaligned access: base 0x1002.
        u_if.req_valid_i  = 1'b1;
        u_if.req_store_i  = 1'b1;
        u_if.req_base_i   = 32'h0000_1002;
        u_if.req_offset_i = 12'h000;
        u_if.req_wdata_i  = 32'h1111_2222;
        @(negedge clk);
        u_if.req_valid_i  = 1'b0;
`ifdef FP_LSU_MISALIGN_TRAP_EN
        chk("mis_pulse",   32'(u_if.misalign_o), 32'd1);
        chk("mis_erraddr", u_if.err_addr_o, 32'h0000_1002);
        chk("mis_nodreq",  32'(u_if.dccm_req_o), 32'd0);
        chk("mis_ready",   32'(u_if.req_ready_o), 32'd1);
        @(negedge clk);
        chk("mis_pulse_end",  32'(u_if.misalign_o), 32'd0);
        chk("mis_erraddr_hold", u_if.err_addr_o, 32'h0000_1002);
        chk("mis_nodreq2",    32'(u_if.dccm_req_o), 32'd0);
`else
        chk("mis_tied",    32'(u_if.misalign_o), 32'd0);
        chk("mis_errtied", u_if.err_addr_o, 32'h0);
        chk("mis_dreq",    32'(u_if.dccm_req_o), 32'd1);
        chk("mis_addr",    u_if.dccm_addr_o, 32'h0000_1000);
        chk("mis_wdata",   u_if.dccm_wdata_o, 32'h1111_2222);
        u_if.dccm_gnt_i = 1'b1;
        @(negedge clk);
        u_if.dccm_gnt_i = 1'b0;
        chk("mis_st_ready", 32'(u_if.req_ready_o), 32'd1);
`endif

        // Reset while in WAIT, then a late rvalid.
        u_if.req_valid_i  = 1'b1;
        u_if.req_store_i  = 1'b0;
        u_if.req_frd_i    = 5'd9;
        u_if.req_base_i   = 32'h0000_3000;
        u_if.req_offset_i = 12'h020;
        @(negedge clk);
        u_if.req_valid_i  = 1'b0;
        u_if.dccm_gnt_i   = 1'b1;
        @(negedge clk);
        u_if.dccm_gnt_i   = 1'b0;
        chk("rw_in_wait_busy", 32'(u_if.busy_o), 32'd1);
        chk("rw_in_wait_addr", u_if.dccm_addr_o, 32'h0000_3020);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all_zero("rstwait");
        u_if.dccm_rvalid_i = 1'b1;
        u_if.dccm_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk);
        u_if.dccm_rvalid_i = 1'b0;
        chk("rw_late_wbv",    32'(u_if.wb_valid_o), 32'd0);
        chk("rw_late_data",   u_if.wb_data_o, 32'h0);
        chk("rw_late_ready",  32'(u_if.req_ready_o), 32'd1);
        @(negedge clk);
        chk("rw_late_wbv2",   32'(u_if.wb_valid_o), 32'd0);
        chk("rw_late_dreq",   32'(u_if.dccm_req_o), 32'd0);
        chk("rw_late_busy",   32'(u_if.busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_lsu.md
# fp_lsu

Load/store unit for the floating-point register file: accepts one FLW/FSW request at a time from the FP decode stage and computes the effective address. It runs the word access against the DCCM over a request/grant/rvalid handshake. For loads, it returns the read word to the FP register file through a valid/ready writeback port. It sits between the FP issue logic and the DCCM arbiter and is the memory-side counterpart of the FP register file's load/store ports.

## Interface
- `ADDR_W`, 32, width of base register, effective address and DCCM address.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  unit can accept a request.
- `req_store_i`  in  1  1 = FSW, 0 = FLW.
- `req_frd_i`  in  5  FP destination register for loads.
- `req_base_i`  in  ADDR_W  integer rs1 value.
- `req_offset_i`  in  12  immediate; sign-extended.
- `req_wdata_i`  in  32  FP rs2 value for stores.
- `dccm_req_o`  out  1  DCCM access request.
- `dccm_gnt_i`  in  1  DCCM accepts the current request.
- `dccm_we_o`  out  1  write enable.
- `dccm_addr_o`  out  ADDR_W  word address.
- `dccm_wdata_o`  out  32  store data.
- `dccm_rvalid_i`  in  1  read data valid.
- `dccm_rdata_i`  in  32  read data.
- `wb_valid_o`  out  1  load result valid.
- `wb_ready_i`  in  1  register file accepts the writeback.
- `wb_frd_o`  out  5  destination register.
- `wb_data_o`  out  32  loaded word.
- `busy_o`  out  1  state != IDLE.
- `misalign_o`  out  1  misaligned-access pulse; only with the macro, otherwise tied 0.
- `err_addr_o`  out  ADDR_W  faulting address; only with the macro, otherwise tied 0.

## Operation
- Effective address = `req_base_i` + sign-extended `req_offset_i`, computed modulo 2^ADDR_W. Wrap-around is legal and produces no error.
- A request is accepted on a cycle with `req_valid_i && req_ready_o`. The unit registers the address, data, `frd` and store flag on that cycle.
- `req_ready_o` = (state == IDLE). The unit holds at most one request in flight.
- FSM states:
  - IDLE to ISSUE on accept.
  - ISSUE: `dccm_req_o`=1 with `dccm_we_o`/`dccm_addr_o`/`dccm_wdata_o` held stable until `dccm_gnt_i`. On grant, a store goes to IDLE and a load goes to WAIT.
  - WAIT: on `dccm_rvalid_i`, capture `dccm_rdata_i` into the result register and go to WB.
  - WB: `wb_valid_o`=1 with `wb_frd_o`/`wb_data_o` held stable until `wb_ready_i`, then IDLE.
- `dccm_rvalid_i` outside WAIT is ignored. This includes an rvalid arriving in the same cycle as the grant and any late response after reset.
- `dccm_wdata_o` is driven 0 for loads.
- Reset mid-operation aborts the access: the FSM returns to IDLE and every registered output returns to 0 on the next edge. An access that was already granted is not replayed.

## Timing
- Reset values: `req_ready_o`=1, `busy_o`=0; all other outputs 0.
- Accept at cycle N gives `dccm_req_o` high at N+1.
- Store with immediate grant at N+1: `req_ready_o` is high again at N+2, so the minimum store occupancy is 2 cycles.
- Load with grant at N+1 and rvalid at N+2: `wb_valid_o` at N+3. If `wb_ready_i` is high, the unit is back in IDLE at N+4.
- Grant stalls add cycles in ISSUE, rvalid delay adds cycles in WAIT, and writeback backpressure adds cycles in WB. There is no timeout.
- No combinational path from any input to `req_ready_o`. `dccm_*` and `wb_*` outputs are driven from registers.

## Configuration
- Macro `FP_LSU_MISALIGN_TRAP_EN`.
- Defined: an effective address with [1:0] != 0 makes no DCCM access. The FSM stays in IDLE, `misalign_o` pulses for one cycle at N+1, and `err_addr_o` holds the full address until the next misaligned accept or reset. `req_ready_o` stays 1.
- Not defined: address bits [1:0] are forced to 00 and the access proceeds normally. `misalign_o` and `err_addr_o` are tied 0.

## Test plan
- Reset, then load with base 0x1000 and offset 0x010: `dccm_addr_o`=0x1010, `dccm_we_o`=0. DCCM grants immediately and returns 0x3F800000 one cycle later: `wb_valid_o` is set with frd=5 and data 0x3F800000 after 3 cycles.
- Store with base 0x2000, offset 0xFFC (-4) and data 0xDEADBEEF: `dccm_addr_o`=0x1FFC with `dccm_we_o`=1. `gnt` held low for 3 cycles: request and address stay stable, then `req_ready_o` returns 1 cycle after grant.
- Load with base 0xFFFFFFFC and offset 0x008: `dccm_addr_o`=0x00000004 (wrap), no error.
- Load with `wb_ready_i` low for 4 cycles: `wb_valid_o` and `wb_data_o` stay stable and `req_ready_o` stays 0. A spurious `dccm_rvalid_i` arriving during WB is ignored.
- Base 0x1002 with the macro defined: `misalign_o` pulses with `err_addr_o`=0x1002 and there is no `dccm_req_o`. Without the macro: `dccm_addr_o`=0x1000.
- Assert `rst_i` while in WAIT, then drive `dccm_rvalid_i`: all outputs are 0, `req_ready_o`=1 and there is no writeback.
